// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard_if
//  Description : Pipeline-side bundle for the register-write scoreboard:
//                Id source/destination info, Ex kill, Wb retirement, and
//                the stall / pending / error results returned to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if;
    // Id stage
    logic [4:0]  IdRs;
    logic [4:0]  IdRt;
    logic        IdUseRs;
    logic        IdUseRt;
    logic [4:0]  IdRd;
    logic        IdWb;
    logic        IdIssue;
    // Ex stage
    logic [4:0]  ExRd;
    logic        ExWb;
    logic        ExKill;
    // Wb stage
    logic [4:0]  WbRd;
    logic        WbWb;
    // Results
    logic        Stall;
    logic [31:0] PendingMask;
    logic        Error;

    // Pipeline side: drives stage information, consumes the stall
    modport master (
        output IdRs, IdRt, IdUseRs, IdUseRt, IdRd, IdWb, IdIssue,
        output ExRd, ExWb, ExKill,
        output WbRd, WbWb,
        input  Stall, PendingMask, Error
    );

    // Scoreboard side
    modport slave (
        input  IdRs, IdRt, IdUseRs, IdUseRt, IdRd, IdWb, IdIssue,
        input  ExRd, ExWb, ExKill,
        input  WbRd, WbWb,
        output Stall, PendingMask, Error
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-GPR in-flight write counter. Issue from Id adds a
//                pending write; Wb retirement or an Ex kill removes one.
//                Decode stalls on RAW hazards against unretired writes and
//                when a destination counter is saturated. Wb retirement is
//                bypassed into the hazard check (write-through regfile).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int CNTW = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    reg_scoreboard_if.slave sb
);

    localparam logic        [CNTW-1:0] c_CNT_MAX = '1;
    localparam logic        [CNTW-1:0] c_CNT_ONE = CNTW'(1);
    localparam logic signed [CNTW+1:0] c_SUM_MAX = $signed({2'b00, c_CNT_MAX});

    // Per-register status vectors; bit 0 is r0, which is never tracked
    logic [31:0] w_busy;     // pending write not retiring this cycle
    logic [31:0] w_full;     // counter saturated and not retiring this cycle
    logic [31:0] w_pending;  // registered counter is non-zero
    logic [31:0] w_clamp;    // next-count clamp fired this cycle
    logic        w_stall;
    logic        r_error;

    assign w_busy[0]    = 1'b0;
    assign w_full[0]    = 1'b0;
    assign w_pending[0] = 1'b0;
    assign w_clamp[0]   = 1'b0;

    // Stall does not look at IdIssue, so the issue qualifier below that
    // depends on it does not close a combinational loop.
    assign w_stall = (sb.IdUseRs && w_busy[sb.IdRs])
                  || (sb.IdUseRt && w_busy[sb.IdRt])
                  || (sb.IdWb    && w_full[sb.IdRd]);

    for (genvar r = 1; r < 32; r++) begin : g_reg
        logic [CNTW-1:0]        r_cnt;
        logic                   w_ret;
        logic                   w_inc;
        logic                   w_kill;
        logic signed [CNTW+1:0] w_sum;
        logic [CNTW-1:0]        w_next;
        logic                   w_err;

        assign w_ret  = sb.WbWb && (sb.WbRd == 5'(r));
        assign w_kill = sb.ExKill && sb.ExWb && (sb.ExRd == 5'(r));
        assign w_inc  = sb.IdIssue && !w_stall && sb.IdWb && (sb.IdRd == 5'(r));

        // Busy means (Cnt - Ret) > 0; only a count of exactly one can be
        // cancelled by a same-cycle retirement.
        assign w_busy[r]    = (r_cnt != '0) && !((r_cnt == c_CNT_ONE) && w_ret);
        assign w_full[r]    = (r_cnt == c_CNT_MAX) && !w_ret;
        assign w_pending[r] = (r_cnt != '0);

        // Issue, retire and kill net out arithmetically with two guard bits
        assign w_sum = $signed({2'b00, r_cnt})
                     + $signed({{(CNTW+1){1'b0}}, w_inc})
                     - $signed({{(CNTW+1){1'b0}}, w_ret})
                     - $signed({{(CNTW+1){1'b0}}, w_kill});

        // Saturate the next count into [0, max] and flag any clamp
        always_comb begin
            w_next = w_sum[CNTW-1:0];
            w_err  = 1'b0;
            if (w_sum[CNTW+1]) begin
                w_next = '0;
                w_err  = 1'b1;
            end else if (w_sum > c_SUM_MAX) begin
                w_next = c_CNT_MAX;
                w_err  = 1'b1;
            end
        end

        assign w_clamp[r] = w_err;

        // Pending-write counter for this register
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_next;
            end
        end
    end

    // Sticky error: any underflow or overflow clamp until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (|w_clamp) begin
            r_error <= 1'b1;
        end
    end

    assign sb.Stall       = w_stall;
    assign sb.PendingMask = w_pending;
    assign sb.Error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Directed self-checking bench for reg_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reg_scoreboard_if sbIf ();

    reg_scoreboard #(.CNTW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        sbIf.IdRs    = '0;
        sbIf.IdRt    = '0;
        sbIf.IdUseRs = 1'b0;
        sbIf.IdUseRt = 1'b0;
        sbIf.IdRd    = '0;
        sbIf.IdWb    = 1'b0;
        sbIf.IdIssue = 1'b0;
        sbIf.ExRd    = '0;
        sbIf.ExWb    = 1'b0;
        sbIf.ExKill  = 1'b0;
        sbIf.WbRd    = '0;
        sbIf.WbWb    = 1'b0;
    endtask

    // Inputs change 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        sbIf.IdIssue = 1'b1;
        sbIf.IdWb    = 1'b1;
        sbIf.IdRd    = rd;
    endtask

    task automatic test_reset();
        doReset();
        sbIf.IdUseRs = 1'b1;
        sbIf.IdRs    = 5'd5;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", sbIf.Stall);
        end
        checks++;
        if (sbIf.PendingMask !== 32'h0) begin
            errors++; $display("FAIL reset_mask: got %h expected 00000000", sbIf.PendingMask);
        end
        checks++;
        if (sbIf.Error !== 1'b0) begin
            errors++; $display("FAIL reset_error: got %b expected 0", sbIf.Error);
        end
    endtask

    task automatic test_raw_stall();
        doReset();
        issue(5'd8);
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL raw_issue_stall: got %b expected 0", sbIf.Stall);
        end
        tick();
        // dependent reader sits in Id for cycles 1 and 2
        for (int c = 1; c <= 2; c++) begin
            idle();
            sbIf.IdIssue = 1'b1;
            sbIf.IdUseRs = 1'b1;
            sbIf.IdRs    = 5'd8;
            #1;
            checks++;
            if (sbIf.Stall !== 1'b1) begin
                errors++; $display("FAIL raw_stall_c%0d: got %b expected 1", c, sbIf.Stall);
            end
            checks++;
            if (sbIf.PendingMask !== 32'h0000_0100) begin
                errors++; $display("FAIL raw_mask_c%0d: got %h expected 00000100", c, sbIf.PendingMask);
            end
            tick();
        end
        sbIf.WbWb = 1'b1;
        sbIf.WbRd = 5'd8;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL raw_bypass_stall: got %b expected 0", sbIf.Stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (sbIf.PendingMask !== 32'h0) begin
            errors++; $display("FAIL raw_retired_mask: got %h expected 00000000", sbIf.PendingMask);
        end
    endtask

    task automatic test_rt_operand();
        doReset();
        issue(5'd3);
        tick();
        idle();
        sbIf.IdUseRt = 1'b1;
        sbIf.IdRt    = 5'd3;
        sbIf.IdRs    = 5'd3;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b1) begin
            errors++; $display("FAIL rt_stall: got %b expected 1", sbIf.Stall);
        end
        sbIf.IdUseRt = 1'b0;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL rt_unused_stall: got %b expected 0", sbIf.Stall);
        end
    endtask

    task automatic test_waw_overflow();
        doReset();
        for (int i = 0; i < 3; i++) begin
            issue(5'd9);
            #1;
            checks++;
            if (sbIf.Stall !== 1'b0) begin
                errors++; $display("FAIL waw_issue%0d_stall: got %b expected 0", i, sbIf.Stall);
            end
            tick();
        end
        issue(5'd9);
        #1;
        checks++;
        if (sbIf.Stall !== 1'b1) begin
            errors++; $display("FAIL waw_full_stall: got %b expected 1", sbIf.Stall);
        end
        tick();
        // retirement frees a slot in the same cycle: fourth issue accepted
        sbIf.WbWb = 1'b1;
        sbIf.WbRd = 5'd9;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL waw_retire_stall: got %b expected 0", sbIf.Stall);
        end
        tick();
        issue(5'd9);
        #1;
        checks++;
        if (sbIf.Stall !== 1'b1) begin
            errors++; $display("FAIL waw_refull_stall: got %b expected 1", sbIf.Stall);
        end
        // drain three writes: count must go 3 -> 2 -> 1 -> 0
        for (int i = 2; i >= 0; i--) begin
            idle();
            sbIf.WbWb = 1'b1;
            sbIf.WbRd = 5'd9;
            tick();
            idle();
            #1;
            checks++;
            if (sbIf.PendingMask !== ((i != 0) ? 32'h0000_0200 : 32'h0)) begin
                errors++; $display("FAIL waw_drain_to%0d_mask: got %h expected %h", i,
                                   sbIf.PendingMask, (i != 0) ? 32'h0000_0200 : 32'h0);
            end
        end
        checks++;
        if (sbIf.Error !== 1'b0) begin
            errors++; $display("FAIL waw_error: got %b expected 0", sbIf.Error);
        end
    endtask

    task automatic test_kill();
        doReset();
        issue(5'd12);
        tick();
        idle();
        sbIf.ExKill = 1'b1;
        sbIf.ExWb   = 1'b1;
        sbIf.ExRd   = 5'd12;
        tick();
        idle();
        #1;
        checks++;
        if (sbIf.PendingMask !== 32'h0) begin
            errors++; $display("FAIL kill_mask: got %h expected 00000000", sbIf.PendingMask);
        end
        checks++;
        if (sbIf.Error !== 1'b0) begin
            errors++; $display("FAIL kill_error: got %b expected 0", sbIf.Error);
        end
        sbIf.WbWb = 1'b1;
        sbIf.WbRd = 5'd12;
        tick();
        idle();
        #1;
        checks++;
        if (sbIf.Error !== 1'b1) begin
            errors++; $display("FAIL underflow_error: got %b expected 1", sbIf.Error);
        end
        tick();
        tick();
        checks++;
        if (sbIf.Error !== 1'b1) begin
            errors++; $display("FAIL error_sticky: got %b expected 1", sbIf.Error);
        end
        checks++;
        if (sbIf.PendingMask !== 32'h0) begin
            errors++; $display("FAIL underflow_mask: got %h expected 00000000", sbIf.PendingMask);
        end
    endtask

    task automatic test_r0();
        doReset();
        issue(5'd0);
        sbIf.IdUseRs = 1'b1;
        sbIf.IdUseRt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (sbIf.Stall !== 1'b0) begin
                errors++; $display("FAIL r0_stall_c%0d: got %b expected 0", c, sbIf.Stall);
            end
            tick();
        end
        checks++;
        if (sbIf.PendingMask !== 32'h0) begin
            errors++; $display("FAIL r0_mask: got %h expected 00000000", sbIf.PendingMask);
        end
        idle();
        sbIf.WbWb = 1'b1;
        sbIf.WbRd = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (sbIf.Error !== 1'b0) begin
            errors++; $display("FAIL r0_retire_error: got %b expected 0", sbIf.Error);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        issue(5'd4);
        tick();
        issue(5'd4);
        tick();
        // Cnt[4]=2: issue, retire and kill together net to 1
        issue(5'd4);
        sbIf.WbWb   = 1'b1;
        sbIf.WbRd   = 5'd4;
        sbIf.ExKill = 1'b1;
        sbIf.ExWb   = 1'b1;
        sbIf.ExRd   = 5'd4;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL net_stall: got %b expected 0", sbIf.Stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (sbIf.PendingMask !== 32'h0000_0010) begin
            errors++; $display("FAIL net_mask: got %h expected 00000010", sbIf.PendingMask);
        end
        checks++;
        if (sbIf.Error !== 1'b0) begin
            errors++; $display("FAIL net_error: got %b expected 0", sbIf.Error);
        end
        // Cnt[4]=1 is fully cancelled by a same-cycle retirement
        sbIf.IdUseRs = 1'b1;
        sbIf.IdRs    = 5'd4;
        sbIf.WbWb    = 1'b1;
        sbIf.WbRd    = 5'd4;
        #1;
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL net_count_one: got %b expected 0", sbIf.Stall);
        end
        // reset dominates a concurrent issue to r7
        reset        = 1'b1;
        sbIf.IdIssue = 1'b1;
        sbIf.IdWb    = 1'b1;
        sbIf.IdRd    = 5'd7;
        tick();
        reset = 1'b0;
        idle();
        sbIf.IdUseRs = 1'b1;
        sbIf.IdRs    = 5'd4;
        #1;
        checks++;
        if (sbIf.PendingMask !== 32'h0) begin
            errors++; $display("FAIL post_reset_mask: got %h expected 00000000", sbIf.PendingMask);
        end
        checks++;
        if (sbIf.Stall !== 1'b0) begin
            errors++; $display("FAIL post_reset_stall: got %b expected 0", sbIf.Stall);
        end
        checks++;
        if (sbIf.Error !== 1'b0) begin
            errors++; $display("FAIL post_reset_error: got %b expected 0", sbIf.Error);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_raw_stall();
        test_rt_operand();
        test_waw_overflow();
        test_kill();
        test_r0();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-write scoreboard for the pipelined MIPS core. It sits beside the decode (Id) stage and is the consumer of the per-stage destination-register information the pipeline produces. It counts in-flight writes per GPR: an instruction leaving Id adds a write, and Wb retirement or an Ex-stage kill removes it. It raises a decode stall whenever an Id-stage source operand, or a WAW overflow, depends on a write that has not yet retired.

## Interface
Parameters:
- CNTW, 2, width of per-register pending counter; max in-flight writes per register = 2^CNTW-1 (3).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- IdRs  input  5  Id-stage source register A.
- IdRt  input  5  Id-stage source register B.
- IdUseRs  input  1  Id instruction reads IdRs.
- IdUseRt  input  1  Id instruction reads IdRt.
- IdRd  input  5  Id-stage destination register.
- IdWb  input  1  Id instruction writes IdRd.
- IdIssue  input  1  Id instruction attempts to advance to Ex this cycle.
- ExRd  input  5  destination of instruction currently in Ex.
- ExWb  input  1  Ex instruction writes ExRd.
- ExKill  input  1  Ex instruction is squashed this cycle (branch/exception).
- WbRd  input  5  destination being written back.
- WbWb  input  1  write-back occurs this cycle.
- Stall  output  1  hold Id stage (combinational).
- PendingMask  output  32  bit r = 1 when register r has ≥1 pending write (registered).
- Error  output  1  sticky underflow/overflow flag (registered).

## Operation
- State: 31 counters Cnt[1..31] of CNTW bits each; register 0 is never tracked, and Cnt[0], PendingMask[0] are constant 0.
- Retire-this-cycle: Ret[r] = WbWb && WbRd==r && r!=0. The register file is write-through, so a register whose only pending write retires this cycle is treated as ready.
- Busy[r] = (Cnt[r] - Ret[r]) > 0.
- Stall = (IdUseRs && Busy[IdRs]) || (IdUseRt && Busy[IdRt]) || (IdWb && IdRd!=0 && Cnt[IdRd]==max && !Ret[IdRd]).
- Accepted issue: Inc[r] = IdIssue && !Stall && IdWb && IdRd==r && r!=0. IdIssue while Stall=1 has no effect.
- Kill: Dec_k[r] = ExKill && ExWb && ExRd==r && r!=0.
- Next count: Cnt[r] + Inc[r] - Ret[r] - Dec_k[r], computed in CNTW+2 signed bits.
  - A result below 0 clamps to 0 and sets Error.
  - A result above max clamps to max and sets Error. This is unreachable when Stall is honoured.
- Retire, kill and issue on the same register in the same cycle net out arithmetically. Example: Cnt=2, all three events on that register → Cnt=1.
- PendingMask[r] = (Cnt[r] != 0), taken from the registered counters.
- Error stays set until reset.

## Timing
- Reset (synchronous, clk edge with reset=1): all Cnt=0; PendingMask=0; Error=0. Stall then evaluates to 0 for any inputs.
- reset dominates every other input in the same cycle.
- Stall: zero-cycle latency; a pure function of current Cnt and this cycle's Id/Wb inputs. It does not depend on IdIssue, so there is no combinational loop.
- Count update and PendingMask: visible one cycle after the issuing, retiring or killing edge.
- Nominal path: issue at edge N → Ex at N+1 → Mem at N+2 → Wb at N+3. A dependent instruction in Id stalls for cycles N+1 and N+2 and is released in cycle N+3, when Ret bypasses the counter.
- Reset mid-operation: in-flight counts are discarded. Later WbWb for those registers underflows, so the clamp sets Error. The pipeline must therefore be flushed together with reset.

## Test plan
- Reset, then IdUseRs=1 IdRs=5 with no writes → Stall=0, PendingMask=0, Error=0.
- Issue IdRd=8 IdWb=1 at cycle 0; next Id reads IdRs=8 → Stall=1 in cycles 1–2. WbWb=1 WbRd=8 in cycle 3 → Stall=0 in cycle 3, PendingMask[8]=0 in cycle 4.
- Issue three writes to r9 back-to-back, then a fourth with IdWb=1 IdRd=9 → Stall=1, Cnt[9] stays 3. Retire one r9 in the same cycle → Stall=0, the fourth issue is accepted, Cnt[9]=3.
- Issue to r12, then ExKill=1 ExWb=1 ExRd=12 next cycle → PendingMask[12]=0 one cycle later, no Error. A later WbWb for r12 → Error=1 and stays set.
- Writes and reads to r0 (IdRd=0 IdWb=1, IdRs=0) → never Stall, PendingMask=0.
- Cnt[4]=2 with simultaneous accepted issue, retire and kill on r4 → Cnt[4]=1, PendingMask[4]=1. Reset the next cycle → all outputs 0.
